// File: rtl/tx_key_scheduler.sv
// tx_key_scheduler: debounces the four active-low board keys, latches each
// press as a pending transmit request and grants requests round-robin to the
// TX serializer through a start/busy handshake. HEX0 shows the last symbol sent.
module tx_key_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 10000,
    parameter int unsigned ACK_TIMEOUT     = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] KEY,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [1:0] tx_sym,
    output logic [3:0] pending,
    output logic [6:0] HEX0
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TMO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       db;
    logic [3:0]       db_q;
    logic [CNT_W-1:0] db_cnt [4];
    logic [3:0]       press;

    logic [1:0]       ptr;
    logic [1:0]       grant_idx;
    logic [1:0]       scan_idx;
    logic             grant_vld;
    logic [TMO_W-1:0] tmo_cnt;

    logic             do_grant;
    logic             do_timeout;
    logic             do_done;
    logic [3:0]       pend_clr;
    logic [3:0]       pend_set;

    // Active-low seven-segment pattern (gfedcba) for a symbol index.
    function automatic logic [6:0] seg7(input logic [1:0] d);
        case (d)
            2'd0:    seg7 = 7'b1000000;
            2'd1:    seg7 = 7'b1111001;
            2'd2:    seg7 = 7'b0100100;
            default: seg7 = 7'b0110000;
        endcase
    endfunction

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    // Per-key debounce: accept a new level only after it has been stable long enough.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db <= '1;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Previous debounced level, used to detect the 1->0 press edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_q <= '1;
        end else begin
            db_q <= db;
        end
    end

    assign press = db_q & ~db;

    // Round-robin search starting at ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr;
        scan_idx  = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            scan_idx = ptr + 2'(i);
            if (!grant_vld && pending[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state and handshake control.
    always_comb begin
        state_nx   = state;
        tx_start   = 1'b0;
        do_grant   = 1'b0;
        do_timeout = 1'b0;
        do_done    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld && !tx_busy) begin
                    do_grant = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                state_nx = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (tmo_cnt == TMO_MAX) begin
                    do_timeout = 1'b1;
                    state_nx   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    do_done  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pending masks: grant clears its bit, timeout re-arms the failed symbol.
    always_comb begin
        pend_clr = '0;
        pend_set = '0;
        if (do_grant) begin
            pend_clr[grant_idx] = 1'b1;
        end
        if (do_timeout) begin
            pend_set[tx_sym] = 1'b1;
        end
    end

    // Acknowledge timeout counter, cleared while issuing the start pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt <= '0;
        end else if (state == START) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_ACK) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Request bookkeeping and display; a new press outranks a same-cycle grant clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_sym  <= '0;
            ptr     <= '0;
            pending <= '0;
            HEX0    <= '1;
        end else begin
            if (do_grant) begin
                tx_sym <= grant_idx;
                ptr    <= grant_idx + 2'd1;
            end else if (do_timeout) begin
                ptr <= tx_sym;
            end
            pending <= (pending & ~pend_clr) | press | pend_set;
            if (do_done) begin
                HEX0 <= seg7(tx_sym);
            end
        end
    end

endmodule

// File: tb/tb_tx_key_scheduler.sv
// Bench for tx_key_scheduler: serializer model, scoreboard of expected
// symbols consumed on each tx_start, and cycle-exact checks on key timing.
module tb_tx_key_scheduler;

    localparam int unsigned DB  = 16;
    localparam int unsigned TMO = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] KEY = 4'hF;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [1:0] tx_sym;
    logic [3:0] pending;
    logic [6:0] HEX0;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_start = 0;
    int ser_phase = 0;
    bit ser_en  = 1'b1;
    int exp_q[$];

    tx_key_scheduler #(
        .DEBOUNCE_CYCLES(DB),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .KEY(KEY),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_sym(tx_sym),
        .pending(pending),
        .HEX0(HEX0)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serializer: busy rises 2 cycles after a start pulse and stays up 10 cycles.
    always @(negedge CLK) begin
        if (RST || !ser_en) begin
            ser_phase = 0;
            tx_busy   = 1'b0;
        end else if (ser_phase == 0) begin
            if (tx_start === 1'b1) ser_phase = 1;
        end else begin
            ser_phase++;
            if (ser_phase == 3) tx_busy = 1'b1;
            if (ser_phase == 13) begin
                tx_busy   = 1'b0;
                ser_phase = 0;
            end
        end
    end

    // Scoreboard: each start pulse consumes the next expected symbol.
    always @(negedge CLK) begin : mon
        int e;
        if (tx_start === 1'b1) begin
            n_start++;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 4;
            check("tx_sym", 32'(tx_sym), e);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        KEY = 4'hF;
        wait_neg(3);
        RST = 1'b0;
    endtask

    initial begin : main
        int s0;

        // Reset state
        wait_neg(3);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_sym", tx_sym, 0);
        check("rst_pending", pending, 0);
        check("rst_hex", HEX0, 7'b1111111);
        RST = 1'b0;

        // Single press of KEY0 held 40 cycles
        exp_q.push_back(0);
        KEY = 4'b1110;
        wait_neg(19);
        check("t1_pend_set", pending, 4'b0001);
        check("t1_no_start_yet", tx_start, 0);
        wait_neg(1);
        check("t1_start", tx_start, 1);
        check("t1_pend_clr", pending, 4'b0000);
        wait_neg(12);
        check("t1_hex_before", HEX0, 7'b1111111);
        wait_neg(1);
        check("t1_hex_after", HEX0, 7'b1000000);
        wait_neg(7);
        KEY = 4'b1111;
        wait_neg(40);
        check("t1_pend_end", pending, 0);
        check("t1_starts", n_start, 1);

        // All four keys at once: grants 0,1,2,3
        do_reset();
        s0 = n_start;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        KEY = 4'b0000;
        wait_neg(19);
        check("t2_pend_all", pending, 4'b1111);
        wait_neg(1);
        check("t2_pend_after0", pending, 4'b1110);
        wait_neg(20);
        KEY = 4'b1111;
        wait_neg(60);
        check("t2_starts", n_start - s0, 4);
        check("t2_hex", HEX0, 7'b0110000);
        check("t2_pend_end", pending, 0);

        // Short glitches on KEY2 are filtered
        s0 = n_start;
        for (int g = 0; g < 10; g++) begin
            KEY[2] = 1'b0;
            wait_neg(5);
            KEY[2] = 1'b1;
            wait_neg(5);
            check("t3_glitch_pend", pending, 0);
        end
        wait_neg(30);
        check("t3_starts", n_start - s0, 0);

        // Serializer silent: start repeats after each acknowledge timeout
        ser_en = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(1);
        KEY = 4'b1101;
        wait_neg(19);
        check("t4_pend_set", pending, 4'b0010);
        wait_neg(1);
        check("t4_start0", tx_start, 1);
        KEY = 4'b1111;
        wait_neg(9);
        check("t4_pend_rearm", pending, 4'b0010);
        check("t4_gap_low", tx_start, 0);
        wait_neg(1);
        check("t4_start1", tx_start, 1);
        wait_neg(9);
        check("t4_gap_low2", tx_start, 0);
        wait_neg(1);
        check("t4_start2", tx_start, 1);
        check("t4_hex_blank", HEX0, 7'b1111111);
        do_reset();
        ser_en = 1'b1;

        // Reset during WAIT_DONE with KEY3 pending
        do_reset();
        exp_q.push_back(1);
        KEY = 4'b1101;
        wait_neg(5);
        KEY = 4'b0101;
        wait_neg(23);
        check("t5_pre_pend", pending, 4'b1000);
        check("t5_pre_busy", tx_busy, 1);
        check("t5_pre_sym", tx_sym, 1);
        RST = 1'b1;
        #1;
        check("t5_rst_start", tx_start, 0);
        check("t5_rst_sym", tx_sym, 0);
        check("t5_rst_pend", pending, 0);
        check("t5_rst_hex", HEX0, 7'b1111111);
        KEY = 4'b1111;
        s0 = n_start;
        wait_neg(3);
        RST = 1'b0;
        wait_neg(60);
        check("t5_no_start", n_start - s0, 0);
        check("t5_pend_end", pending, 0);

        // KEY3 re-press lands on the cycle its pending bit is granted
        do_reset();
        s0 = n_start;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(3);
        KEY = 4'b0000;
        wait_neg(20);
        KEY = 4'b1111;
        wait_neg(23);
        KEY = 4'b0111;
        wait_neg(19);
        check("t6_start3", tx_start, 1);
        check("t6_sym3", tx_sym, 3);
        check("t6_pend_kept", pending, 4'b1000);
        wait_neg(8);
        KEY = 4'b1111;
        wait_neg(40);
        check("t6_starts", n_start - s0, 5);
        check("t6_hex", HEX0, 7'b0110000);
        check("t6_pend_end", pending, 0);

        check("q_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
